// File: rtl/mix_up_pro.sv
// mix_up_pro: I/Q digital upconverter, DAC_DAT = round(I*cos - Q*sin) driven by a 32-bit NCO.
// Define UPMIX_SAT_EN to clamp out-of-range results; by default they wrap to 16 bits.
module mix_up_pro (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               PHASE_CLR,
    input  logic        [31:0] PHI_INC,
    input  logic               BB_VALID,
    input  logic signed [15:0] BB_DATI,
    input  logic signed [15:0] BB_DATQ,
    output logic signed [15:0] DAC_DAT,
    output logic               DAC_VALID,
    output logic               OVF
);
    // Quarter-wave table: round(32767*sin(2*pi*k/256)) for k = 0..64.
    localparam logic [15:0] QTAB [0:64] = '{
        16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
        16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
        16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
        16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
        16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
        16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
        16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
        16'd32767
    };

    logic        [31:0] ph;
    logic signed [15:0] hi, hq;
    logic        [7:0]  idx;
    logic        [15:0] t_fwd, t_rev;
    logic signed [15:0] cos_c, sin_c;

    logic signed [15:0] cos1, sin1, hi1, hq1;
    logic signed [31:0] pi2, pq2;
    logic signed [32:0] d3;
    logic signed [17:0] r4;
    logic               v1, v2, v3, v4;
    logic signed [15:0] lim;
    logic               out_of_range;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph <= '0;
            hi <= '0;
            hq <= '0;
        end else begin
            if (PHASE_CLR)
                ph <= '0;
            else if (EN)
                ph <= ph + PHI_INC;
            if (BB_VALID) begin
                hi <= BB_DATI;
                hq <= BB_DATQ;
            end
        end
    end

    assign idx   = ph[31:24];
    assign t_fwd = QTAB[{1'b0, idx[5:0]}];
    assign t_rev = QTAB[7'd64 - {1'b0, idx[5:0]}];

    // Quadrant folding of the quarter-wave table into full-period sin/cos.
    always_comb begin
        sin_c = $signed(t_fwd);
        cos_c = $signed(t_rev);
        case (idx[7:6])
            2'd0: begin sin_c =  $signed(t_fwd); cos_c =  $signed(t_rev); end
            2'd1: begin sin_c =  $signed(t_rev); cos_c = -$signed(t_fwd); end
            2'd2: begin sin_c = -$signed(t_fwd); cos_c = -$signed(t_rev); end
            default: begin sin_c = -$signed(t_rev); cos_c = $signed(t_fwd); end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cos1 <= '0; sin1 <= '0; hi1 <= '0; hq1 <= '0; v1 <= 1'b0;
            pi2  <= '0; pq2  <= '0; v2  <= 1'b0;
            d3   <= '0; v3   <= 1'b0;
            r4   <= '0; v4   <= 1'b0;
        end else begin
            cos1 <= cos_c;
            sin1 <= sin_c;
            hi1  <= hi;
            hq1  <= hq;
            v1   <= EN;
            pi2  <= 32'(hi1) * 32'(cos1);
            pq2  <= 32'(hq1) * 32'(sin1);
            v2   <= v1;
            d3   <= 33'(pi2) - 33'(pq2);
            v3   <= v2;
            // Round half up, then drop the Q15 fraction.
            r4   <= 18'((d3 + 33'sd16384) >>> 15);
            v4   <= v3;
        end
    end

    assign out_of_range = (r4 > 18'sd32767) || (r4 < -18'sd32768);

`ifdef UPMIX_SAT_EN
    always_comb begin
        lim = r4[15:0];
        if (r4 > 18'sd32767)
            lim = 16'sh7fff;
        else if (r4 < -18'sd32768)
            lim = 16'sh8000;
    end
`else
    assign lim = r4[15:0];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DAC_DAT   <= '0;
            DAC_VALID <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            DAC_DAT   <= v4 ? lim : '0;
            DAC_VALID <= v4;
            OVF       <= v4 & out_of_range;
        end
    end
endmodule

// File: tb/tb_mix_up_pro.sv
// Bench for mix_up_pro: directed test-plan cases plus randomized traffic against
// a behavioural NCO/mixer model built from real-valued sine math.
module tb_mix_up_pro;
    logic               CLK = 1'b0;
    logic               RST;
    logic               EN;
    logic               PHASE_CLR;
    logic        [31:0] PHI_INC;
    logic               BB_VALID;
    logic signed [15:0] BB_DATI;
    logic signed [15:0] BB_DATQ;
    logic signed [15:0] DAC_DAT;
    logic               DAC_VALID;
    logic               OVF;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: phase, held sample, and one expected output per edge.
    int          tbl [0:64];
    logic [31:0] m_ph;
    int          m_hi, m_hq;
    logic [17:0] exp_q[$];

    mix_up_pro dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PHASE_CLR(PHASE_CLR), .PHI_INC(PHI_INC),
        .BB_VALID(BB_VALID), .BB_DATI(BB_DATI), .BB_DATQ(BB_DATQ),
        .DAC_DAT(DAC_DAT), .DAC_VALID(DAC_VALID), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Expected {valid, ovf, dat} for the phase/sample present at an edge.
    function automatic logic [17:0] ref_out(input logic [31:0] ph, input int hi, input int hq, input logic en);
        int idx, q, i, s, c;
        longint d, r;
        logic ov;
        logic [15:0] dat;
        idx = int'(ph >> 24);
        q = idx / 64;
        i = idx % 64;
        case (q)
            0: begin s = tbl[i];      c = tbl[64 - i];  end
            1: begin s = tbl[64 - i]; c = -tbl[i];      end
            2: begin s = -tbl[i];     c = -tbl[64 - i]; end
            default: begin s = -tbl[64 - i]; c = tbl[i]; end
        endcase
        d = longint'(hi) * c - longint'(hq) * s;
        r = (d + 16384) >>> 15;
        ov = (r > 32767) || (r < -32768);
`ifdef UPMIX_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        dat = r[15:0];
        if (!en) return 18'd0;
        return {1'b1, ov, dat};
    endfunction

    task automatic model_reset();
        m_ph = '0;
        m_hi = 0;
        m_hq = 0;
        exp_q.delete();
        repeat (4) exp_q.push_back(18'd0);
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        logic [17:0] e;
        @(posedge CLK);
        exp_q.push_back(ref_out(m_ph, m_hi, m_hq, EN));
        if (PHASE_CLR) m_ph = '0;
        else if (EN) m_ph = m_ph + PHI_INC;
        if (BB_VALID) begin
            m_hi = BB_DATI;
            m_hq = BB_DATQ;
        end
        #1;
        e = exp_q.pop_front();
        check("dac_valid", 32'(DAC_VALID), 32'(e[17]));
        check("ovf", 32'(OVF), 32'(e[16]));
        check("dac_dat", 32'(DAC_DAT), 32'($signed(e[15:0])));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dat"}, 32'(DAC_DAT), 0);
        check({tag, "_valid"}, 32'(DAC_VALID), 0);
        check({tag, "_ovf"}, 32'(OVF), 0);
    endtask

    task automatic idle_inputs();
        EN = 1'b0; PHASE_CLR = 1'b0; PHI_INC = '0;
        BB_VALID = 1'b0; BB_DATI = '0; BB_DATQ = '0;
    endtask

    initial begin
        int n_low, first_low;
        logic signed [31:0] pat [0:3];

        for (int k = 0; k <= 64; k++)
            tbl[k] = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * k / 256.0) + 0.5));

        // Power-on reset.
        idle_inputs();
        RST = 1'b1;
        #2;
        check_zero("por");
        @(posedge CLK); #1;
        check_zero("por_held");
        RST = 1'b0;
        model_reset();

        // DC, I only.
        PHI_INC = '0; EN = 1'b1; BB_VALID = 1'b1; BB_DATI = 16'sd16384; BB_DATQ = '0;
        tick();
        BB_VALID = 1'b0;
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("dc_i", 32'(DAC_DAT), 16384);
            check("dc_ovf", 32'(OVF), 0);
        end

        // fs/4 carrier, I only; PHASE_CLR and EN together clear rather than advance.
        PHASE_CLR = 1'b1; PHI_INC = 32'h4000_0000; BB_VALID = 1'b1; BB_DATI = 16'sd16384; BB_DATQ = '0;
        tick();
        PHASE_CLR = 1'b0; BB_VALID = 1'b0;
        repeat (4) tick();
        pat[0] = 16384; pat[1] = 0; pat[2] = -16383; pat[3] = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("fs4_i", 32'(DAC_DAT), pat[k % 4]);
        end

        // fs/4 carrier, Q only: -Q*sin.
        PHASE_CLR = 1'b1; BB_VALID = 1'b1; BB_DATI = '0; BB_DATQ = 16'sd16384;
        tick();
        PHASE_CLR = 1'b0; BB_VALID = 1'b0;
        repeat (4) tick();
        pat[0] = 0; pat[1] = -16383; pat[2] = 0; pat[3] = 16384;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("fs4_q", 32'(DAC_DAT), pat[k % 4]);
        end

        // Overflow at idx 32 (cos = sin = 23170): R = 46339.
        EN = 1'b0; PHASE_CLR = 1'b1; PHI_INC = 32'h2000_0000;
        BB_VALID = 1'b1; BB_DATI = 16'sd32767; BB_DATQ = -16'sd32768;
        tick();
        PHASE_CLR = 1'b0; BB_VALID = 1'b0; EN = 1'b1;
        tick();
        PHI_INC = '0;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ovf_flag", 32'(OVF), 1);
`ifdef UPMIX_SAT_EN
            check("ovf_dat", 32'(DAC_DAT), 32767);
`else
            check("ovf_dat", 32'(DAC_DAT), -19197);
`endif
        end

        // EN gating: 10 low cycles appear 4 edges later, phase resumes.
        PHI_INC = 32'h0123_4567; EN = 1'b1; BB_VALID = 1'b1; BB_DATI = 16'sd12000; BB_DATQ = -16'sd9000;
        tick();
        BB_VALID = 1'b0;
        repeat (20) tick();
        n_low = 0;
        first_low = 0;
        for (int k = 1; k <= 40; k++) begin
            EN = (k <= 10) ? 1'b0 : 1'b1;
            tick();
            if (!DAC_VALID) begin
                n_low++;
                if (first_low == 0) first_low = k;
            end
        end
        check("en_gap_len", n_low, 10);
        check("en_gap_start", first_low, 5);

        // Reset mid-stream: outputs clear immediately, then restart from PH = 0.
        repeat (7) tick();
        #2 RST = 1'b1;
        #1 check_zero("rst_async");
        @(posedge CLK); #1;
        check_zero("rst_held");
        RST = 1'b0;
        model_reset();
        PHI_INC = '0; EN = 1'b1; BB_VALID = 1'b1; BB_DATI = 16'sd16384; BB_DATQ = '0;
        tick();
        BB_VALID = 1'b0;
        repeat (4) tick();
        tick();
        check("rst_restart", 32'(DAC_DAT), 16384);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            EN        = ($urandom_range(0, 9) != 0);
            PHASE_CLR = ($urandom_range(0, 39) == 0);
            BB_VALID  = ($urandom_range(0, 3) == 0);
            BB_DATI   = 16'($urandom);
            BB_DATQ   = 16'($urandom);
            if ($urandom_range(0, 19) == 0) PHI_INC = $urandom;
            tick();
            if (k == 700) begin
                #2 RST = 1'b1;
                #1 check_zero("rst_rand");
                @(posedge CLK); #1;
                RST = 1'b0;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
